// File: rtl/sdram_responder_if.sv
// sdram_responder_if: SDR SDRAM pin bundle; master = controller side, slave = device side (addr/ba/strobes/cke/dqm/dq_in in, dq_out/dq_oe out)
interface sdram_responder_if #(parameter int ROW_BITS = 13) ();
  logic [ROW_BITS-1:0] addr;
  logic [1:0] ba;
  logic cs_n;
  logic ras_n;
  logic cas_n;
  logic we_n;
  logic cke;
  logic [1:0] dqm;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic dq_oe;
  modport master (output addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm, dq_in, input dq_out, dq_oe);
  modport slave (input addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm, dq_in, output dq_out, dq_oe);
endinterface

// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device model over an aliased RAM; ports clk_clk, reset_reset, sdram_wire (slave), mode_reg, err_pulse, err_code
module sdram_responder #(
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 10,
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic clk_clk,
  input  logic reset_reset,
  sdram_responder_if.slave sdram_wire,
  output logic [ROW_BITS-1:0] mode_reg,
  output logic err_pulse,
  output logic [2:0] err_code
);
  typedef logic [MEM_ADDR_BITS-1:0] idx_t;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;
  logic [15:0] mem [2**MEM_ADDR_BITS];
  logic [3:0] open_q, open_d;
  logic [ROW_BITS-1:0] row_q [4];
  logic [ROW_BITS-1:0] row_d [4];
  logic mode_loaded_q, mode_loaded_d, cl3_q, cl3_d, single_q, single_d;
  logic [ROW_BITS-1:0] mode_q, mode_d;
  logic [3:0] bl_q, bl_d;
  logic [2:0] rd_left_q, rd_left_d, wr_left_q, wr_left_d;
  logic [1:0] rd_ba_q, rd_ba_d, wr_ba_q, wr_ba_d;
  logic [ROW_BITS-1:0] rd_row_q, rd_row_d, wr_row_q, wr_row_d;
  logic [COL_BITS-1:0] rd_col_q, rd_col_d, wr_col_q, wr_col_d;
  logic p1_v_q, p1_v_d, p2_v_q, p2_v_d;
  idx_t p1_i_q, p1_i_d, p2_i_q, p2_i_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic dq_oe_q, dq_oe_d, err_pulse_q, err_pulse_d;
  logic [2:0] err_code_q, err_code_d;
  logic mem_we;
  idx_t mem_i;
  logic [2:0] cmd;
  logic [1:0] ba;
  logic [COL_BITS-1:0] col;
  function automatic idx_t idx(input logic [1:0] b, input logic [ROW_BITS-1:0] r, input logic [COL_BITS-1:0] c);
    return idx_t'({b, r, c});
  endfunction
  // next burst column, wrapping inside the BL-aligned block
  function automatic logic [COL_BITS-1:0] nxt(input logic [COL_BITS-1:0] c, input logic [3:0] bl);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(bl - 4'd1);
    return (c & ~m) | ((c + 1'b1) & m);
  endfunction
  assign cmd = sdram_wire.cs_n ? 3'b111 : {sdram_wire.ras_n, sdram_wire.cas_n, sdram_wire.we_n};
  assign ba = sdram_wire.ba;
  assign col = sdram_wire.addr[COL_BITS-1:0];
  // read beats are issued one per edge into p1, then appear on dq_out CL-1 edges after issue
  always_comb begin
    open_d = open_q;
    row_d = row_q;
    mode_loaded_d = mode_loaded_q;
    mode_d = mode_q;
    cl3_d = cl3_q;
    bl_d = bl_q;
    single_d = single_q;
    rd_left_d = rd_left_q;
    rd_ba_d = rd_ba_q;
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    wr_left_d = wr_left_q;
    wr_ba_d = wr_ba_q;
    wr_row_d = wr_row_q;
    wr_col_d = wr_col_q;
    p1_v_d = p1_v_q;
    p1_i_d = p1_i_q;
    p2_v_d = p2_v_q;
    p2_i_d = p2_i_q;
    dq_out_d = dq_out_q;
    dq_oe_d = dq_oe_q;
    err_pulse_d = err_pulse_q;
    err_code_d = err_code_q;
    mem_we = 1'b0;
    mem_i = idx(wr_ba_q, wr_row_q, wr_col_q);
    if (sdram_wire.cke) begin
      err_pulse_d = 1'b0;
      p2_v_d = p1_v_q;
      p2_i_d = p1_i_q;
      p1_v_d = rd_left_q != 3'd0;
      p1_i_d = idx(rd_ba_q, rd_row_q, rd_col_q);
      dq_oe_d = cl3_q ? p2_v_q : p1_v_q;
      if (dq_oe_d) dq_out_d = mem[cl3_q ? p2_i_q : p1_i_q];
      if (rd_left_q != 3'd0) begin
        rd_col_d = nxt(rd_col_q, bl_q);
        rd_left_d = rd_left_q - 3'd1;
      end
      mem_we = wr_left_q != 3'd0;
      if (mem_we) begin
        wr_col_d = nxt(wr_col_q, bl_q);
        wr_left_d = wr_left_q - 3'd1;
      end
      if (cmd == C_ACT) begin
        if (open_q[ba]) begin
          err_pulse_d = 1'b1;
          err_code_d = 3'd1;
        end
        open_d[ba] = 1'b1;
        row_d[ba] = sdram_wire.addr;
      end else if (cmd == C_PRE) begin
        if (sdram_wire.addr[10]) open_d = 4'd0;
        else open_d[ba] = 1'b0;
        if (sdram_wire.addr[10] || ba == wr_ba_q) begin
          mem_we = 1'b0;
          wr_left_d = 3'd0;
        end
        if (sdram_wire.addr[10] || ba == rd_ba_q) begin
          p1_v_d = 1'b0;
          rd_left_d = 3'd0;
        end
      end else if (cmd == C_REF) begin
        if (|open_q) begin
          err_pulse_d = 1'b1;
          err_code_d = 3'd2;
        end
      end else if (cmd == C_LMR) begin
        if (|open_q) begin
          err_pulse_d = 1'b1;
          err_code_d = 3'd5;
        end else begin
          mode_d = sdram_wire.addr;
          mode_loaded_d = 1'b1;
          cl3_d = sdram_wire.addr[6:4] != 3'd2;
          bl_d = sdram_wire.addr[2] ? 4'd1 : 4'd1 << sdram_wire.addr[1:0];
          single_d = sdram_wire.addr[9];
          if (sdram_wire.addr[6:5] != 2'b01 || sdram_wire.addr[2]) begin
            err_pulse_d = 1'b1;
            err_code_d = 3'd6;
          end
        end
      end else if (cmd == C_RD || cmd == C_WR) begin
        if (!open_q[ba]) begin
          err_pulse_d = 1'b1;
          err_code_d = 3'd3;
        end else if (!mode_loaded_q) begin
          err_pulse_d = 1'b1;
          err_code_d = 3'd4;
        end else if (cmd == C_RD) begin
          p1_v_d = 1'b1;
          p1_i_d = idx(ba, row_q[ba], col);
          rd_ba_d = ba;
          rd_row_d = row_q[ba];
          rd_col_d = nxt(col, bl_q);
          rd_left_d = 3'(bl_q - 4'd1);
          mem_we = 1'b0;
          wr_left_d = 3'd0;
        end else begin
          p1_v_d = 1'b0;
          p2_v_d = 1'b0;
          dq_oe_d = 1'b0;
          rd_left_d = 3'd0;
          mem_we = 1'b1;
          mem_i = idx(ba, row_q[ba], col);
          wr_ba_d = ba;
          wr_row_d = row_q[ba];
          wr_col_d = nxt(col, bl_q);
          wr_left_d = single_q ? 3'd0 : 3'(bl_q - 4'd1);
        end
      end
    end
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      open_q <= 4'd0;
      row_q <= '{default: '0};
      mode_loaded_q <= 1'b0;
      mode_q <= '0;
      cl3_q <= 1'b1;
      bl_q <= 4'd1;
      single_q <= 1'b0;
      rd_left_q <= 3'd0;
      rd_ba_q <= 2'd0;
      rd_row_q <= '0;
      rd_col_q <= '0;
      wr_left_q <= 3'd0;
      wr_ba_q <= 2'd0;
      wr_row_q <= '0;
      wr_col_q <= '0;
      p1_v_q <= 1'b0;
      p1_i_q <= '0;
      p2_v_q <= 1'b0;
      p2_i_q <= '0;
      dq_out_q <= 16'd0;
      dq_oe_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      open_q <= open_d;
      row_q <= row_d;
      mode_loaded_q <= mode_loaded_d;
      mode_q <= mode_d;
      cl3_q <= cl3_d;
      bl_q <= bl_d;
      single_q <= single_d;
      rd_left_q <= rd_left_d;
      rd_ba_q <= rd_ba_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
      wr_left_q <= wr_left_d;
      wr_ba_q <= wr_ba_d;
      wr_row_q <= wr_row_d;
      wr_col_q <= wr_col_d;
      p1_v_q <= p1_v_d;
      p1_i_q <= p1_i_d;
      p2_v_q <= p2_v_d;
      p2_i_q <= p2_i_d;
      dq_out_q <= dq_out_d;
      dq_oe_q <= dq_oe_d;
      err_pulse_q <= err_pulse_d;
      err_code_q <= err_code_d;
    end
  end
  always_ff @(posedge clk_clk) begin
    if (mem_we && !reset_reset) begin
      if (!sdram_wire.dqm[0]) mem[mem_i][7:0] <= sdram_wire.dq_in[7:0];
      if (!sdram_wire.dqm[1]) mem[mem_i][15:8] <= sdram_wire.dq_in[15:8];
    end
  end
  assign sdram_wire.dq_out = dq_out_q;
  assign sdram_wire.dq_oe = dq_oe_q;
  assign mode_reg = mode_q;
  assign err_pulse = err_pulse_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: cycle-by-cycle directed vectors against sdram_responder
module tb_sdram_responder;
  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010, REF = 3'b001, LMR = 3'b000;
  typedef struct {
    logic cs_n;
    logic cke;
    logic [2:0] cmd;
    logic [1:0] ba;
    logic [12:0] addr;
    logic [1:0] dqm;
    logic [15:0] din;
    logic oe;
    logic [15:0] dout;
    logic ep;
    logic [2:0] ec;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [12:0] mode_reg;
  logic err_pulse;
  logic [2:0] err_code;
  int total = 0;
  int bad = 0;
  vec_t tbl[$];
  vec_t v;
  sdram_responder_if #(.ROW_BITS(13)) sw ();
  sdram_responder dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .sdram_wire(sw),
    .mode_reg(mode_reg),
    .err_pulse(err_pulse),
    .err_code(err_code)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [2:0] cmd, logic [1:0] ba, logic [12:0] addr, logic [1:0] dqm, logic [15:0] din,
                              logic oe, logic [15:0] dout, logic ep, logic [2:0] ec);
    vec_t r;
    r.cs_n = 1'b0;
    r.cke = 1'b1;
    r.cmd = cmd;
    r.ba = ba;
    r.addr = addr;
    r.dqm = dqm;
    r.din = din;
    r.oe = oe;
    r.dout = dout;
    r.ep = ep;
    r.ec = ec;
    return r;
  endfunction
  function automatic vec_t nop(logic [15:0] din, logic oe, logic [15:0] dout, logic [2:0] ec);
    return mk(NOP, 2'd0, 13'd0, 2'd0, din, oe, dout, 1'b0, ec);
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t x, input string tag);
    sw.cs_n = x.cs_n;
    sw.cke = x.cke;
    {sw.ras_n, sw.cas_n, sw.we_n} = x.cmd;
    sw.ba = x.ba;
    sw.addr = x.addr;
    sw.dqm = x.dqm;
    sw.dq_in = x.din;
    @(posedge clk);
    #1;
    chk($sformatf("%s oe", tag), 16'(sw.dq_oe), 16'(x.oe));
    chk($sformatf("%s err_pulse", tag), 16'(err_pulse), 16'(x.ep));
    chk($sformatf("%s err_code", tag), 16'(err_code), 16'(x.ec));
    if (x.oe) chk($sformatf("%s dq_out", tag), sw.dq_out, x.dout);
  endtask
  initial begin
    sw.cs_n = 1'b0;
    sw.cke = 1'b1;
    {sw.ras_n, sw.cas_n, sw.we_n} = NOP;
    sw.ba = 2'd0;
    sw.addr = 13'd0;
    sw.dqm = 2'd0;
    sw.dq_in = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset oe", 16'(sw.dq_oe), 16'd0);
    chk("reset dq_out", sw.dq_out, 16'd0);
    chk("reset err_pulse", 16'(err_pulse), 16'd0);
    chk("reset err_code", 16'(err_code), 16'd0);
    chk("reset mode_reg", 16'(mode_reg), 16'd0);
    rst = 1'b0;
    // CL2 BL1 write then read
    tbl.push_back(mk(LMR, 2'd0, 13'h020, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(ACT, 2'd1, 13'd5, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(WR, 2'd1, 13'h010, 2'd0, 16'hBEEF, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(RD, 2'd1, 13'h010, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(nop(16'd0, 1'b1, 16'hBEEF, 3'd0));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd0));
    // CL3 BL8 wrapping write and read from col 6
    tbl.push_back(mk(PRE, 2'd0, 13'h400, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(LMR, 2'd0, 13'h033, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(ACT, 2'd1, 13'd5, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(WR, 2'd1, 13'd6, 2'd0, 16'h00A0, 1'b0, 16'd0, 1'b0, 3'd0));
    for (int k = 1; k < 8; k++) tbl.push_back(nop(16'h00A0 + 16'(k), 1'b0, 16'd0, 3'd0));
    tbl.push_back(mk(RD, 2'd1, 13'd6, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd0));
    for (int k = 0; k < 8; k++) tbl.push_back(nop(16'd0, 1'b1, 16'h00A0 + 16'(k), 3'd0));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd0));
    // wrap check: col 0 holds beat 2; byte-masked overwrite
    tbl.push_back(mk(PRE, 2'd0, 13'h400, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(LMR, 2'd0, 13'h020, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(ACT, 2'd1, 13'd5, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(RD, 2'd1, 13'd0, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(nop(16'd0, 1'b1, 16'h00A2, 3'd0));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd0));
    tbl.push_back(mk(WR, 2'd1, 13'h020, 2'd0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(WR, 2'd1, 13'h020, 2'b10, 16'h1234, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(RD, 2'd1, 13'h020, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(nop(16'd0, 1'b1, 16'hFF34, 3'd0));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd0));
    // protocol errors
    tbl.push_back(mk(PRE, 2'd0, 13'h400, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd0));
    tbl.push_back(mk(RD, 2'd1, 13'd0, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd3));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd3));
    tbl.push_back(mk(ACT, 2'd0, 13'd1, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd3));
    tbl.push_back(mk(ACT, 2'd0, 13'd2, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd1));
    tbl.push_back(mk(REF, 2'd0, 13'd0, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd2));
    tbl.push_back(mk(LMR, 2'd0, 13'h020, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd5));
    tbl.push_back(mk(PRE, 2'd0, 13'h400, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd5));
    tbl.push_back(mk(LMR, 2'd0, 13'h070, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd6));
    v = mk(RD, 2'd1, 13'd0, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6);
    v.cs_n = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk(LMR, 2'd0, 13'h024, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd6));
    // CL3 BL4 read cancelled by a write two edges later
    tbl.push_back(mk(LMR, 2'd0, 13'h032, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6));
    tbl.push_back(mk(ACT, 2'd2, 13'd7, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6));
    tbl.push_back(mk(RD, 2'd2, 13'd0, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd6));
    tbl.push_back(mk(WR, 2'd2, 13'h040, 2'd0, 16'h5A00, 1'b0, 16'd0, 1'b0, 3'd6));
    for (int k = 1; k < 4; k++) tbl.push_back(nop(16'h5A00 + 16'(k), 1'b0, 16'd0, 3'd6));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd6));
    tbl.push_back(mk(RD, 2'd2, 13'h040, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd6));
    for (int k = 0; k < 4; k++) tbl.push_back(nop(16'd0, 1'b1, 16'h5A00 + 16'(k), 3'd6));
    tbl.push_back(nop(16'd0, 1'b0, 16'd0, 3'd6));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));
    chk("mode_reg 032", 16'(mode_reg), 16'h0032);
    // reset in the middle of a BL8 read
    apply(mk(PRE, 2'd0, 13'h400, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6), "r0");
    apply(mk(LMR, 2'd0, 13'h033, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6), "r1");
    apply(mk(ACT, 2'd1, 13'd5, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6), "r2");
    apply(mk(RD, 2'd1, 13'd6, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd6), "r3");
    apply(nop(16'd0, 1'b0, 16'd0, 3'd6), "r4");
    for (int k = 0; k < 3; k++) apply(nop(16'd0, 1'b1, 16'h00A0 + 16'(k), 3'd6), $sformatf("rb%0d", k));
    rst = 1'b1;
    apply(nop(16'd0, 1'b0, 16'd0, 3'd0), "rst_mid");
    chk("rst_mid mode_reg", 16'(mode_reg), 16'd0);
    rst = 1'b0;
    apply(mk(RD, 2'd1, 13'd6, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd3), "pr0");
    apply(nop(16'd0, 1'b0, 16'd0, 3'd3), "pr1");
    apply(mk(ACT, 2'd1, 13'd5, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd3), "pr2");
    apply(mk(RD, 2'd1, 13'd6, 2'd0, 16'd0, 1'b0, 16'd0, 1'b1, 3'd4), "pr3");
    // RAM contents survive reset
    apply(mk(PRE, 2'd0, 13'h400, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd4), "pr4");
    apply(mk(LMR, 2'd0, 13'h020, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd4), "pr5");
    apply(mk(ACT, 2'd1, 13'd5, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd4), "pr6");
    apply(mk(RD, 2'd1, 13'd6, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd4), "pr7");
    apply(nop(16'd0, 1'b1, 16'h00A0, 3'd4), "pr8");
    // cke low freezes the pipeline and ignores the command
    apply(mk(RD, 2'd1, 13'd7, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd4), "ck0");
    v = mk(ACT, 2'd1, 13'd5, 2'd0, 16'd0, 1'b0, 16'd0, 1'b0, 3'd4);
    v.cke = 1'b0;
    apply(v, "ck1");
    apply(nop(16'd0, 1'b1, 16'h00A1, 3'd4), "ck2");
    apply(nop(16'd0, 1'b0, 16'd0, 3'd4), "ck3");
    chk("mode_reg 020", 16'(mode_reg), 16'h0020);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
